// File: rtl/ama_riscv_hpm_csr.sv
// Hardware performance-monitor CSR bank: mcycle, minstret, NUM_HPM event counters,
// their event selectors and mcountinhibit behind a registered single-cycle CSR port.
module ama_riscv_hpm_csr #(
  parameter int unsigned NUM_HPM    = 4,
  parameter int unsigned CNT_WIDTH  = 64,
  parameter int unsigned NUM_EVENTS = 16,
  parameter int unsigned RET_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csr_en,
  input  logic                  csr_we,
  input  logic [11:0]           csr_addr,
  input  logic [31:0]           csr_wdata,
  output logic [31:0]           csr_rdata,
  output logic                  csr_rvalid,
  output logic                  csr_illegal,
  input  logic [RET_W-1:0]      ret_cnt,
  input  logic [NUM_EVENTS-1:0] events,
  output logic [NUM_HPM+1:0]    ovf
);

  localparam int unsigned NCNT  = NUM_HPM + 2;
  localparam int unsigned SEL_W = $clog2(NUM_EVENTS);
  localparam int unsigned EV_N  = 1 << SEL_W;
  localparam int unsigned HI_W  = CNT_WIDTH - 32;

  // Counter slot k: 0 = mcycle, 1 = minstret, 2+i = mhpmcounter(3+i)
  function automatic logic [11:0] lo_addr(input int unsigned k);
    return (k == 0) ? 12'hB00 : 12'hB01 + 12'(k);
  endfunction

  function automatic int unsigned inh_bit(input int unsigned k);
    return (k == 0) ? 0 : k + 1;
  endfunction

  function automatic logic [31:0] inh_mask();
    logic [31:0] m;
    m = '0;
    for (int unsigned k = 0; k < NCNT; k++) m[inh_bit(k)] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0] INH_MASK = inh_mask();

  logic [CNT_WIDTH-1:0] cnt     [NCNT];
  logic [CNT_WIDTH-1:0] cnt_nxt [NCNT];
  logic [CNT_WIDTH-1:0] inc     [NCNT];
  logic [CNT_WIDTH:0]   sum     [NCNT];
  logic [SEL_W-1:0]     sel     [NUM_HPM];
  logic [31:0]          inhibit;
  logic [NCNT-1:0]      ovf_nxt;
  logic [NCNT-1:0]      hit_lo;
  logic [NCNT-1:0]      hit_hi;
  logic [NUM_HPM-1:0]   hit_sel;
  logic                 hit_inh;
  logic                 implemented;
  logic                 wr;
  logic                 rd;
  logic [31:0]          rd_mux;
  logic [EV_N-1:0]      ev_pad;

  assign wr = csr_en & csr_we;
  assign rd = csr_en & ~csr_we;

  always_comb begin
    hit_lo  = '0;
    hit_hi  = '0;
    hit_sel = '0;
    hit_inh = (csr_addr == 12'h320);
    for (int unsigned k = 0; k < NCNT; k++) begin
      hit_lo[k] = (csr_addr == lo_addr(k));
      hit_hi[k] = (csr_addr == (lo_addr(k) | 12'h080));
    end
    for (int unsigned i = 0; i < NUM_HPM; i++)
      hit_sel[i] = (csr_addr == 12'h323 + 12'(i));
    implemented = (|hit_lo) | (|hit_hi) | (|hit_sel) | hit_inh;
  end

  // Padding to a power of two lets an out-of-range selector index a zero bit
  always_comb begin
    ev_pad = '0;
    ev_pad[NUM_EVENTS-1:0] = events;
  end

  always_comb begin
    inc[0] = CNT_WIDTH'(1'b1);
    inc[1] = CNT_WIDTH'(ret_cnt);
    for (int unsigned i = 0; i < NUM_HPM; i++)
      inc[2+i] = CNT_WIDTH'((sel[i] != '0) && ev_pad[sel[i]]);
    for (int unsigned k = 0; k < NCNT; k++) begin
      sum[k] = {1'b0, cnt[k]};
      if (!inhibit[inh_bit(k)]) sum[k] = sum[k] + {1'b0, inc[k]};
      cnt_nxt[k] = sum[k][CNT_WIDTH-1:0];
      ovf_nxt[k] = ovf[k] | sum[k][CNT_WIDTH];
      // A write to either half discards the increment for the whole counter
      if (wr && hit_lo[k]) begin
        cnt_nxt[k] = {cnt[k][CNT_WIDTH-1:32], csr_wdata};
        ovf_nxt[k] = 1'b0;
      end
      if (wr && hit_hi[k]) begin
        cnt_nxt[k] = {csr_wdata[HI_W-1:0], cnt[k][31:0]};
        ovf_nxt[k] = 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned k = 0; k < NCNT; k++) begin
      if (hit_lo[k]) rd_mux = cnt[k][31:0];
      if (hit_hi[k]) rd_mux = 32'(cnt[k][CNT_WIDTH-1:32]);
    end
    for (int unsigned i = 0; i < NUM_HPM; i++)
      if (hit_sel[i]) rd_mux = 32'(sel[i]);
    if (hit_inh) rd_mux = inhibit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NCNT; k++) cnt[k] <= '0;
      for (int unsigned i = 0; i < NUM_HPM; i++) sel[i] <= '0;
      inhibit <= '0;
      ovf     <= '0;
    end else begin
      for (int unsigned k = 0; k < NCNT; k++) cnt[k] <= cnt_nxt[k];
      ovf <= ovf_nxt;
      if (wr && hit_inh) inhibit <= csr_wdata & INH_MASK;
      for (int unsigned i = 0; i < NUM_HPM; i++)
        if (wr && hit_sel[i]) sel[i] <= csr_wdata[SEL_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_rdata   <= '0;
      csr_rvalid  <= 1'b0;
      csr_illegal <= 1'b0;
    end else begin
      csr_rvalid  <= rd;
      csr_illegal <= csr_en & ~implemented;
      if (rd) csr_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_ama_riscv_hpm_csr.sv
// Self-checking bench for ama_riscv_hpm_csr: directed table, test-plan sequences and
// random traffic compared against a CSR-number-indexed behavioural model.
module tb_ama_riscv_hpm_csr;
  localparam int unsigned NUM_HPM    = 4;
  localparam int unsigned CNT_WIDTH  = 64;
  localparam int unsigned NUM_EVENTS = 16;
  localparam int unsigned RET_W      = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  csr_en = 1'b0;
  logic                  csr_we = 1'b0;
  logic [11:0]           csr_addr = '0;
  logic [31:0]           csr_wdata = '0;
  logic [31:0]           csr_rdata;
  logic                  csr_rvalid;
  logic                  csr_illegal;
  logic [RET_W-1:0]      ret_cnt = '0;
  logic [NUM_EVENTS-1:0] events = '0;
  logic [NUM_HPM+1:0]    ovf;

  ama_riscv_hpm_csr #(
    .NUM_HPM   (NUM_HPM),
    .CNT_WIDTH (CNT_WIDTH),
    .NUM_EVENTS(NUM_EVENTS),
    .RET_W     (RET_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .csr_en     (csr_en),
    .csr_we     (csr_we),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .csr_rdata  (csr_rdata),
    .csr_rvalid (csr_rvalid),
    .csr_illegal(csr_illegal),
    .ret_cnt    (ret_cnt),
    .events     (events),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model state indexed by CSR number offset (0 = cycle, 2 = instret, 3.. = hpm)
  longint unsigned m_cnt [32];
  bit              m_ovf [32];
  int unsigned     m_sel [32];
  logic [31:0]     m_inh;
  logic [31:0]     m_rdata;
  bit              m_rvalid;
  bit              m_illegal;

  function automatic bit is_cnt(input int unsigned idx);
    return idx == 0 || idx == 2 || (idx >= 3 && idx < 3 + NUM_HPM);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
      m_sel[i] = 0;
    end
    m_inh = '0;
    m_rdata = '0;
    m_rvalid = 1'b0;
    m_illegal = 1'b0;
  endtask

  function automatic bit m_lookup(input logic [11:0] a, output logic [31:0] d);
    int unsigned idx;
    idx = 32'(a[4:0]);
    d = '0;
    if (((a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hB80 && a <= 12'hB9F)) && is_cnt(idx)) begin
      d = a[7] ? m_cnt[idx][63:32] : m_cnt[idx][31:0];
      return 1'b1;
    end
    if (a == 12'h320) begin
      d = m_inh;
      return 1'b1;
    end
    if (a >= 12'h323 && a <= 12'h326) begin
      d = m_sel[idx];
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic m_step(input bit en, input bit we, input logic [11:0] a, input logic [31:0] wd,
                        input int unsigned ret, input logic [15:0] ev);
    logic [31:0] d;
    bit impl;
    longint unsigned old, inc;
    int unsigned wr_idx;
    impl = m_lookup(a, d);
    m_rvalid = en && !we;
    m_illegal = en && !impl;
    if (m_rvalid) m_rdata = d;
    wr_idx = 99;
    if (en && we && impl && a >= 12'hB00) wr_idx = 32'(a[4:0]);
    for (int unsigned k = 0; k < 32; k++) begin
      if (is_cnt(k) && !m_inh[k] && k != wr_idx) begin
        if (k == 0) inc = 1;
        else if (k == 2) inc = ret;
        else inc = (m_sel[k] != 0 && m_sel[k] < NUM_EVENTS && ev[m_sel[k]]) ? 1 : 0;
        old = m_cnt[k];
        m_cnt[k] = old + inc;
        if (m_cnt[k] < old) m_ovf[k] = 1'b1;
      end
    end
    if (wr_idx != 99) begin
      if (a[7]) m_cnt[wr_idx][63:32] = wd;
      else m_cnt[wr_idx][31:0] = wd;
      m_ovf[wr_idx] = 1'b0;
    end
    if (en && we && a == 12'h320) m_inh = wd & 32'h0000_007D;
    if (en && we && impl && a >= 12'h323 && a <= 12'h326) m_sel[32'(a[4:0])] = 32'(wd[3:0]);
  endtask

  function automatic logic [NUM_HPM+1:0] m_ovf_vec();
    logic [NUM_HPM+1:0] v;
    v[0] = m_ovf[0];
    v[1] = m_ovf[2];
    for (int i = 0; i < NUM_HPM; i++) v[2+i] = m_ovf[3+i];
    return v;
  endfunction

  task automatic cyc(input bit en, input bit we, input logic [11:0] a, input logic [31:0] wd,
                     input int unsigned ret, input logic [15:0] ev);
    csr_en = en;
    csr_we = we;
    csr_addr = a;
    csr_wdata = wd;
    ret_cnt = RET_W'(ret);
    events = ev;
    m_step(en, we, a, wd, ret, ev);
    @(posedge clk);
    #1;
    chk("rvalid", 64'(csr_rvalid), 64'(m_rvalid));
    chk("illegal", 64'(csr_illegal), 64'(m_illegal));
    chk("rdata", 64'(csr_rdata), 64'(m_rdata));
    chk("ovf", 64'(ovf), 64'(m_ovf_vec()));
    csr_en = 1'b0;
    csr_we = 1'b0;
    ret_cnt = '0;
    events = '0;
  endtask

  task automatic idle(input int n, input int unsigned ret, input logic [15:0] ev);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 12'h000, '0, ret, ev);
  endtask

  task automatic wr_csr(input logic [11:0] a, input logic [31:0] wd);
    cyc(1'b1, 1'b1, a, wd, 0, '0);
  endtask

  task automatic rd_expect(input string nm, input logic [11:0] a, input logic [31:0] exp);
    cyc(1'b1, 1'b0, a, '0, 0, '0);
    chk(nm, 64'(csr_rdata), 64'(exp));
  endtask

  typedef struct {
    bit          we;
    logic [11:0] addr;
    logic [31:0] wdata;
    bit          exp_rv;
    bit          exp_il;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [17];

  logic [11:0] raddr [20] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04, 12'hB05,
                             12'hB06, 12'hB83, 12'hB84, 12'hB85, 12'hB86, 12'hB07, 12'hB01,
                             12'h320, 12'h323, 12'h324, 12'h325, 12'h326, 12'h3FF};

  initial begin
    longint unsigned fc, fr;
    logic [31:0] wd;

    tbl[0]  = '{1'b1, 12'h320, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 12'h320, 32'h0,         1'b1, 1'b0, 32'h0000_007D};
    tbl[2]  = '{1'b1, 12'h323, 32'h0000_0013, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 12'h323, 32'h0,         1'b1, 1'b0, 32'h3};
    tbl[4]  = '{1'b1, 12'h326, 32'h0000_000F, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 12'h326, 32'h0,         1'b1, 1'b0, 32'hF};
    tbl[6]  = '{1'b1, 12'hB03, 32'h1234_5678, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 12'hB83, 32'hCAFE_BABE, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 12'hB03, 32'h0,         1'b1, 1'b0, 32'h1234_5678};
    tbl[9]  = '{1'b0, 12'hB83, 32'h0,         1'b1, 1'b0, 32'hCAFE_BABE};
    tbl[10] = '{1'b0, 12'hB07, 32'h0,         1'b1, 1'b1, 32'h0};
    tbl[11] = '{1'b1, 12'h3FF, 32'h1,         1'b0, 1'b1, 32'h0};
    tbl[12] = '{1'b0, 12'h327, 32'h0,         1'b1, 1'b1, 32'h0};
    tbl[13] = '{1'b0, 12'hB01, 32'h0,         1'b1, 1'b1, 32'h0};
    tbl[14] = '{1'b0, 12'hB06, 32'h0,         1'b1, 1'b0, 32'h0};
    tbl[15] = '{1'b1, 12'h320, 32'h0,         1'b0, 1'b0, 32'h0};
    tbl[16] = '{1'b0, 12'h320, 32'h0,         1'b1, 1'b0, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", 64'(csr_rdata), 64'h0);
    chk("rst_rvalid", 64'(csr_rvalid), 64'h0);
    chk("rst_illegal", 64'(csr_illegal), 64'h0);
    chk("rst_ovf", 64'(ovf), 64'h0);
    rst = 1'b0;
    m_reset();

    idle(10, 0, '0);
    rd_expect("mcycle_after_10", 12'hB00, 32'd10);
    rd_expect("minstret_zero", 12'hB02, 32'd0);
    chk("ovf_clear", 64'(ovf), 64'h0);

    for (int i = 0; i < 17; i++) begin
      cyc(1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata, 0, '0);
      chk($sformatf("tbl%0d_rvalid", i), 64'(csr_rvalid), 64'(tbl[i].exp_rv));
      chk($sformatf("tbl%0d_illegal", i), 64'(csr_illegal), 64'(tbl[i].exp_il));
      if (!tbl[i].we) chk($sformatf("tbl%0d_rdata", i), 64'(csr_rdata), 64'(tbl[i].exp_rd));
    end

    wr_csr(12'hB80, 32'hFFFF_FFFF);
    wr_csr(12'hB00, 32'hFFFF_FFFE);
    idle(2, 0, '0);
    chk("mcycle_wrap_ovf", 64'(ovf[0]), 64'h1);
    rd_expect("mcycle_wrap_lo", 12'hB00, 32'h0);
    rd_expect("mcycle_wrap_hi", 12'hB80, 32'h0);
    wr_csr(12'hB00, 32'd5);
    chk("ovf_cleared_by_write", 64'(ovf[0]), 64'h0);

    wr_csr(12'hB03, 32'h0);
    wr_csr(12'hB83, 32'h0);
    idle(7, 0, 16'h0008);
    idle(4, 0, 16'h0004);
    rd_expect("hpm0_seven", 12'hB03, 32'd7);
    wr_csr(12'h323, 32'h0);
    idle(3, 0, 16'h0008);
    rd_expect("hpm0_sel_off", 12'hB03, 32'd7);

    wr_csr(12'h320, 32'h5);
    fc = m_cnt[0];
    fr = m_cnt[2];
    idle(20, 2, '0);
    rd_expect("mcycle_frozen", 12'hB00, fc[31:0]);
    rd_expect("minstret_frozen", 12'hB02, fr[31:0]);
    wr_csr(12'h320, 32'h0);
    idle(5, 2, '0);
    rd_expect("minstret_plus10", 12'hB02, 32'(fr + 10));

    wr_csr(12'h323, 32'h3);
    cyc(1'b1, 1'b1, 12'hB03, 32'd100, 0, 16'h0008);
    cyc(1'b1, 1'b0, 12'hB03, '0, 0, 16'h0008);
    chk("write_wins_pre_inc_read", 64'(csr_rdata), 64'd100);
    rd_expect("hpm0_after_inc", 12'hB03, 32'd101);

    rd_expect("unimpl_read_data", 12'hB0F, 32'h0);
    chk("unimpl_read_rvalid", 64'(csr_rvalid), 64'h1);
    chk("unimpl_read_illegal", 64'(csr_illegal), 64'h1);
    wr_csr(12'h3FF, 32'hFFFF_FFFF);
    chk("unimpl_write_illegal", 64'(csr_illegal), 64'h1);
    chk("unimpl_write_rvalid", 64'(csr_rvalid), 64'h0);
    rd_expect("hpm0_untouched", 12'hB03, 32'd101);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: wd = 32'hFFFF_FFFF;
        1: wd = 32'hFFFF_FFFE;
        default: wd = $urandom;
      endcase
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, raddr[$urandom_range(0, 19)],
          wd, $urandom_range(0, 3), 16'($urandom));
    end

    csr_en = 1'b1;
    csr_we = 1'b0;
    csr_addr = 12'hB00;
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_rvalid", 64'(csr_rvalid), 64'h0);
    chk("async_rst_rdata", 64'(csr_rdata), 64'h0);
    chk("async_rst_illegal", 64'(csr_illegal), 64'h0);
    chk("async_rst_ovf", 64'(ovf), 64'h0);
    @(posedge clk);
    #1;
    chk("rst_drops_read", 64'(csr_rvalid), 64'h0);
    csr_en = 1'b0;
    rst = 1'b0;
    m_reset();
    idle(3, 0, '0);
    rd_expect("mcycle_after_rerst", 12'hB00, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
